// File: rtl/device_bus_bridge.sv
// Device-segment load/store bridge: one outstanding valid/ready bus transaction at a time,
// with store-over-load arbitration, load kill and a response timeout.
module device_bus_bridge #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_access_stall,
    input  logic              load_req,
    input  logic              load_kill,
    input  logic [XLEN-1:0]   load_addr,
    input  logic              store_req,
    input  logic [XLEN-1:0]   store_addr,
    input  logic [XLEN/8-1:0] store_byte_enable,
    input  logic [XLEN-1:0]   store_data,
    output logic              load_hit,
    output logic              load_miss,
    output logic              load_data_ready,
    output logic [XLEN-1:0]   load_data,
    output logic              store_finished,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [XLEN-1:0]   bus_req_addr,
    output logic [XLEN/8-1:0] bus_req_be,
    output logic [XLEN-1:0]   bus_req_wdata,
    input  logic              bus_resp_valid,
    input  logic [XLEN-1:0]   bus_resp_rdata,
    output logic              err_sticky
);

    localparam int unsigned BeW  = XLEN / 8;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StLdReq, StLdWait, StLdDone, StStReq, StStWait, StStDone
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:2]   addr_q, addr_d;
    logic [BeW-1:0]    be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              killed_q, killed_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_inc;
    logic              in_wait;
    logic              timeout;

    // Stall is informational only; low address bits are dropped on the bus.
    logic [4:0] unused_bits;
    assign unused_bits = {load_access_stall, load_addr[1:0], store_addr[1:0]};

    assign in_wait = (state_q == StLdWait) || (state_q == StStWait);
    assign cnt_inc = cnt_q + 1'b1;
    // A response in the limit cycle wins over the timeout.
    assign timeout = in_wait && !bus_resp_valid && (cnt_inc == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (store_req) begin
                    state_d = StStReq;
                end else if (load_req && !load_kill) begin
                    state_d = StLdReq;
                end
            end
            StLdReq:  if (bus_req_ready) state_d = StLdWait;
            StLdWait: if (bus_resp_valid || timeout) state_d = StLdDone;
            StLdDone: state_d = StIdle;
            StStReq:  if (bus_req_ready) state_d = StStWait;
            StStWait: if (bus_resp_valid || timeout) state_d = StStDone;
            StStDone: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        load_miss       = 1'b0;
        load_data_ready = 1'b0;
        store_finished  = 1'b0;
        bus_req_valid   = 1'b0;
        bus_req_we      = 1'b0;
        bus_req_addr    = '0;
        bus_req_be      = '0;
        bus_req_wdata   = '0;
        unique case (state_q)
            StIdle:   load_miss = load_req && !load_kill;
            StLdReq: begin
                load_miss     = !killed_q;
                bus_req_valid = 1'b1;
                bus_req_addr  = {addr_q, 2'b00};
                bus_req_be    = '1;
            end
            StLdWait: load_miss = !killed_q;
            StLdDone: load_data_ready = !killed_q;
            StStReq: begin
                bus_req_valid = 1'b1;
                bus_req_we    = 1'b1;
                bus_req_addr  = {addr_q, 2'b00};
                bus_req_be    = be_q;
                bus_req_wdata = wdata_q;
            end
            StStDone: store_finished = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        killed_d    = killed_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        cnt_d       = in_wait ? cnt_inc : '0;

        if (state_q == StIdle) begin
            if (store_req) begin
                addr_d  = store_addr[XLEN-1:2];
                be_d    = store_byte_enable;
                wdata_d = store_data;
            end else if (load_req && !load_kill) begin
                addr_d = load_addr[XLEN-1:2];
            end
        end

        if (((state_q == StLdReq) || (state_q == StLdWait)) && load_kill) begin
            killed_d = 1'b1;
        end

        // A killed load still drains its bus transaction but never updates load_data.
        if ((state_q == StLdWait) && !killed_d) begin
            if (bus_resp_valid) begin
                load_data_d = bus_resp_rdata;
            end else if (timeout) begin
                load_data_d = ERR_RDATA;
            end
        end

        if (timeout) begin
            err_d = 1'b1;
        end

        if (state_d == StIdle) begin
            killed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            killed_q    <= 1'b0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            killed_q    <= killed_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    assign load_hit   = 1'b0;
    assign load_data  = load_data_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_device_bus_bridge.sv
// Bench for device_bus_bridge: directed scenarios with literal expectations, then random
// traffic, all continuously compared against a transaction-level model.
module tb_device_bus_bridge;

    localparam int unsigned TOUT = 255;
    localparam logic [31:0] ERR  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_access_stall, load_req, load_kill, store_req;
    logic [31:0] load_addr, store_addr, store_data;
    logic [3:0]  store_byte_enable;
    logic        load_hit, load_miss, load_data_ready, store_finished;
    logic [31:0] load_data;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    device_bus_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .load_access_stall (load_access_stall),
        .load_req          (load_req),
        .load_kill         (load_kill),
        .load_addr         (load_addr),
        .store_req         (store_req),
        .store_addr        (store_addr),
        .store_byte_enable (store_byte_enable),
        .store_data        (store_data),
        .load_hit          (load_hit),
        .load_miss         (load_miss),
        .load_data_ready   (load_data_ready),
        .load_data         (load_data),
        .store_finished    (store_finished),
        .bus_req_valid     (bus_req_valid),
        .bus_req_ready     (bus_req_ready),
        .bus_req_we        (bus_req_we),
        .bus_req_addr      (bus_req_addr),
        .bus_req_be        (bus_req_be),
        .bus_req_wdata     (bus_req_wdata),
        .bus_resp_valid    (bus_resp_valid),
        .bus_resp_rdata    (bus_resp_rdata),
        .err_sticky        (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding transaction described by what has happened to it.
    bit          m_busy, m_store, m_issued, m_done, m_killed, m_err;
    logic [31:0] m_addr, m_data, m_ldata;
    logic [3:0]  m_be;
    int          m_waited;

    task automatic model_compare();
        logic exp_valid, exp_miss;
        exp_valid = m_busy && !m_issued;
        exp_miss  = !m_busy ? (load_req && !load_kill) : (!m_store && !m_killed && !m_done);
        chk("m_load_hit", load_hit, 0);
        chk("m_load_miss", load_miss, exp_miss);
        chk("m_load_data_ready", load_data_ready, m_done && !m_store && !m_killed);
        chk("m_store_finished", store_finished, m_done && m_store);
        chk("m_bus_req_valid", bus_req_valid, exp_valid);
        chk("m_load_data", load_data, m_ldata);
        chk("m_err_sticky", err_sticky, m_err);
        if (exp_valid) begin
            chk("m_bus_req_we", bus_req_we, m_store);
            chk("m_bus_req_addr", bus_req_addr, {m_addr[31:2], 2'b00});
            chk("m_bus_req_be", bus_req_be, m_store ? m_be : 4'hF);
            if (m_store) chk("m_bus_req_wdata", bus_req_wdata, m_data);
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            m_busy = 0; m_done = 0; m_issued = 0; m_killed = 0; m_err = 0; m_ldata = '0;
        end else if (!m_busy) begin
            if (store_req) begin
                m_busy = 1; m_store = 1; m_issued = 0; m_killed = 0;
                m_addr = store_addr; m_be = store_byte_enable; m_data = store_data;
            end else if (load_req && !load_kill) begin
                m_busy = 1; m_store = 0; m_issued = 0; m_killed = 0; m_addr = load_addr;
            end
        end else if (m_done) begin
            m_busy = 0; m_done = 0; m_killed = 0;
        end else begin
            if (!m_store && load_kill) m_killed = 1;
            if (!m_issued) begin
                if (bus_req_ready) begin m_issued = 1; m_waited = 0; end
            end else if (bus_resp_valid) begin
                m_done = 1;
                if (!m_store && !m_killed) m_ldata = bus_resp_rdata;
            end else begin
                m_waited++;
                if (m_waited == TOUT) begin
                    m_done = 1; m_err = 1;
                    if (!m_store && !m_killed) m_ldata = ERR;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_on) model_compare();
        model_advance();
    end

    task automatic clear_inputs();
        load_access_stall = 0; load_req = 0; load_kill = 0; store_req = 0;
        load_addr = '0; store_addr = '0; store_data = '0; store_byte_enable = '0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = '0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        tick(); load_req = 1; load_addr = a; bus_req_ready = 1;
        @(negedge clk); chk("ld_miss_accept", load_miss, 1);
        tick(); load_req = 0;
        @(negedge clk);
        chk("ld_req_valid", bus_req_valid, 1);
        chk("ld_req_we", bus_req_we, 0);
        chk("ld_req_addr", bus_req_addr, {a[31:2], 2'b00});
        chk("ld_miss_req", load_miss, 1);
        tick(); bus_req_ready = 0; bus_resp_valid = 1; bus_resp_rdata = d;
        @(negedge clk); chk("ld_miss_wait", load_miss, 1); chk("ld_rdy_early", load_data_ready, 0);
        tick(); bus_resp_valid = 0;
        @(negedge clk);
        chk("ld_rdy_pulse", load_data_ready, 1);
        chk("ld_miss_done", load_miss, 0);
        chk("ld_data", load_data, d);
        tick();
        @(negedge clk); chk("ld_rdy_once", load_data_ready, 0); chk("ld_data_held", load_data, d);
    endtask

    initial begin
        int vcnt;
        int n;
        bit found;
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        model_on = 1;
        @(negedge clk);
        chk("rst_miss", load_miss, 0);
        chk("rst_valid", bus_req_valid, 0);
        chk("rst_addr", bus_req_addr, 0);
        chk("rst_be", bus_req_be, 0);
        chk("rst_data", load_data, 0);
        chk("rst_err", err_sticky, 0);
        tick(); rst = 0;

        do_load(32'hC000_0004, 32'h1234_5678);

        // Store with ready held off for five cycles.
        tick(); store_req = 1; store_addr = 32'hC000_0010; store_byte_enable = 4'b0011;
        store_data = 32'hAABB_CCDD; bus_req_ready = 0;
        tick(); store_req = 0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus_req_ready = 1;
            @(negedge clk);
            if (bus_req_valid && bus_req_we && bus_req_addr == 32'hC000_0010 &&
                bus_req_be == 4'b0011 && bus_req_wdata == 32'hAABB_CCDD) vcnt++;
            tick();
        end
        bus_req_ready = 0; bus_resp_valid = 1;
        @(negedge clk); chk("st_fin_early", store_finished, 0); chk("st_valid_drop", bus_req_valid, 0);
        tick(); bus_resp_valid = 0;
        @(negedge clk); chk("st_fin_pulse", store_finished, 1); chk("st_valid_cycles", 32'(vcnt), 6);
        tick();
        @(negedge clk); chk("st_fin_once", store_finished, 0);

        // Simultaneous load and store: store goes first.
        tick(); load_req = 1; load_addr = 32'hC000_0008; store_req = 1;
        store_addr = 32'hC000_0030; store_byte_enable = 4'hF; store_data = 32'h0102_0304;
        bus_req_ready = 1;
        @(negedge clk); chk("arb_miss", load_miss, 1); chk("arb_no_bus", bus_req_valid, 0);
        tick(); load_req = 0; store_req = 0;
        @(negedge clk);
        chk("arb_we", bus_req_we, 1);
        chk("arb_addr", bus_req_addr, 32'hC000_0030);
        chk("arb_miss_st", load_miss, 0);
        tick(); bus_req_ready = 0; bus_resp_valid = 1;
        tick(); bus_resp_valid = 0;
        @(negedge clk); chk("arb_fin", store_finished, 1);
        do_load(32'hC000_0008, 32'h0BAD_F00D);

        // Kill during the wait phase.
        tick(); load_req = 1; load_addr = 32'hC000_0020; bus_req_ready = 1;
        tick(); load_req = 0;
        tick(); bus_req_ready = 0; load_kill = 1;
        @(negedge clk); chk("kill_miss_same", load_miss, 1);
        tick(); load_kill = 0; bus_resp_valid = 1; bus_resp_rdata = 32'hDEAD_0001;
        @(negedge clk); chk("kill_miss_drop", load_miss, 0);
        tick(); bus_resp_valid = 0;
        @(negedge clk); chk("kill_no_rdy", load_data_ready, 0); chk("kill_data", load_data, 32'h0BAD_F00D);
        tick();
        @(negedge clk); chk("kill_no_rdy2", load_data_ready, 0);
        do_load(32'hC000_0024, 32'h5555_AAAA);

        // Timeout: no response ever arrives.
        tick(); load_req = 1; load_addr = 32'hC000_0040; bus_req_ready = 1;
        tick(); load_req = 0;
        tick(); bus_req_ready = 0;
        n = 2; found = 0;
        while (!found && n < 600) begin
            @(negedge clk);
            if (load_data_ready) found = 1;
            else begin tick(); n++; end
        end
        chk("tout_seen", 32'(found), 1);
        chk("tout_cycle", 32'(n), 257);
        chk("tout_data", load_data, ERR);
        chk("tout_err", err_sticky, 1);
        repeat (3) tick();
        @(negedge clk); chk("tout_err_held", err_sticky, 1);

        // Reset during store wait; late response must be ignored.
        tick(); store_req = 1; store_addr = 32'hC000_0050; store_byte_enable = 4'h1; bus_req_ready = 1;
        tick(); store_req = 0;
        tick(); bus_req_ready = 0; rst = 1;
        tick(); rst = 0;
        @(negedge clk);
        chk("rstw_fin", store_finished, 0);
        chk("rstw_valid", bus_req_valid, 0);
        chk("rstw_err", err_sticky, 0);
        chk("rstw_data", load_data, 0);
        bus_resp_valid = 1;
        tick(); bus_resp_valid = 0;
        @(negedge clk); chk("rstw_late_fin", store_finished, 0);
        tick();
        @(negedge clk); chk("rstw_late_fin2", store_finished, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst               = ($urandom_range(0, 299) == 0);
            load_req          = ($urandom_range(0, 1) == 1);
            load_kill         = ($urandom_range(0, 6) == 0);
            store_req         = ($urandom_range(0, 3) == 0);
            load_access_stall = ($urandom_range(0, 1) == 1);
            load_addr         = 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
            store_addr        = 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
            store_byte_enable = 4'($urandom_range(0, 15));
            store_data        = $urandom;
            bus_req_ready     = ($urandom_range(0, 1) == 1);
            bus_resp_valid    = ($urandom_range(0, 2) == 0);
            bus_resp_rdata    = $urandom;
        end
        tick();
        clear_inputs();
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/device_bus_bridge.md
Name: device_bus_bridge

Overview:
- Sequences the core's uncached DEVICE-segment (0xC000_0000–0xCFFF_FFFF) load/store traffic onto a single-outstanding valid/ready device bus.
- Sits between Falco's M_DEVICE_* port and the external peripheral interconnect.
- Arbitrates simultaneous load/store requests.
- Produces the core-side miss, data-ready and store-finished handshakes.
- Enforces a response timeout so a dead peripheral cannot hang the pipeline.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, max cycles in a WAIT state before an error completion; must be ≥ 1.
- ERR_RDATA, 32'hFFFF_FFFF, load data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_access_stall  in  1  core pipeline stall (informational only; bridge ignores it)
- load_req  in  1  device load request (LSU stage)
- load_kill  in  1  kill of the current/pending load
- load_addr  in  XLEN  load address
- store_req  in  1  device store request
- store_addr  in  XLEN  store address
- store_byte_enable  in  XLEN/8  store byte mask
- store_data  in  XLEN  store data
- load_hit  out  1  constant 0 (device space is uncached)
- load_miss  out  1  load accepted and outstanding
- load_data_ready  out  1  one-cycle load completion pulse
- load_data  out  XLEN  load result, held until the next load completion
- store_finished  out  1  one-cycle store completion pulse
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus request accepted
- bus_req_we  out  1  1 = write, 0 = read
- bus_req_addr  out  XLEN  word-aligned address (addr[1:0] forced to 0)
- bus_req_be  out  XLEN/8  byte enables (all ones for reads)
- bus_req_wdata  out  XLEN  write data
- bus_resp_valid  in  1  read data / write ack
- bus_resp_rdata  in  XLEN  read data
- err_sticky  out  1  set on any timeout; cleared only by rst

Behaviour:
- Reset: state = IDLE.
  - All outputs 0: load_miss, load_data_ready, load_data, store_finished, bus_req_*, err_sticky.
  - Timeout counter = 0, killed flag = 0.
  - Reset mid-transaction abandons it silently; no completion pulse.
- FSM states: IDLE, LD_REQ, LD_WAIT, LD_DONE, ST_REQ, ST_WAIT, ST_DONE.
- IDLE:
  - store_req wins over load_req when both are high.
    - Latch store_addr/be/data; go to ST_REQ.
    - The concurrent load is not accepted; load_miss = 1 combinationally that cycle; the core re-presents the load.
  - Otherwise load_req && !load_kill: latch load_addr; go to LD_REQ; load_miss = 1 combinationally in that same cycle.
  - load_req && load_kill: ignored.
- LD_REQ:
  - bus_req_valid = 1, we = 0.
  - Payload stable until bus_req_ready.
  - On handshake go to LD_WAIT.
- ST_REQ:
  - bus_req_valid = 1, we = 1.
  - Payload stable until bus_req_ready.
  - On handshake go to ST_WAIT.
- Valid is never dropped before ready; no timeout in REQ states.
- LD_WAIT:
  - On bus_resp_valid, register rdata into load_data and go to LD_DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES first: load_data = ERR_RDATA, set err_sticky, go to LD_DONE.
- ST_WAIT:
  - On bus_resp_valid go to ST_DONE.
  - On timeout set err_sticky and go to ST_DONE.
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Zeroed on entry to a WAIT state; increments each WAIT cycle without response.
  - A response in the same cycle the count hits the limit counts as a normal response.
- LD_DONE:
  - load_data_ready = 1 for exactly one cycle, unless killed; load_miss = 0; return to IDLE.
  - A new request is accepted only in the next IDLE cycle.
- ST_DONE: store_finished = 1 for one cycle; return to IDLE.
- load_miss = 1 in LD_REQ and LD_WAIT, and in the IDLE acceptance cycle.
- Kill:
  - load_kill in LD_REQ/LD_WAIT sets the killed flag; load_miss drops to 0 the next cycle.
  - The bus transaction still completes and the response is discarded: load_data is not updated and there is no load_data_ready pulse.
  - Killed flag clears on IDLE entry.
- A store_req arriving while a load is in flight is not accepted (store_finished stays 0); the core holds it.
- One outstanding transaction at a time.
- Latency:
  - Load with immediate ready and response: 4 cycles from load_req to load_data_ready (IDLE → LD_REQ → LD_WAIT → LD_DONE).
  - Store: 4 cycles from store_req to store_finished.

Test Plan:
- Load 0xC000_0004, ready immediate, resp next cycle with 0x1234_5678 → load_miss high for 3 cycles; load_data_ready pulses at cycle 4; load_data = 0x1234_5678 held afterwards.
- Store 0xC000_0010, be = 4'b0011, data = 0xAABB_CCDD, ready delayed 5 cycles → bus_req_valid held stable 6 cycles; store_finished pulses once after the ack.
- Simultaneous load_req + store_req → store issued first; load_miss = 1 with no bus read; load re-presented after store_finished and completes normally.
- load_kill asserted during LD_WAIT, response 0xDEAD_0001 arrives → no load_data_ready; load_data keeps the previous value; next load works.
- No response for TIMEOUT_CYCLES = 255 cycles → load_data = 0xFFFF_FFFF; load_data_ready pulses; err_sticky = 1 and stays set until rst.
- rst asserted in ST_WAIT → all outputs 0 the next cycle; no store_finished pulse; late bus_resp_valid in IDLE is ignored.
